apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS wait cycles before abort (legal range 2..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset; 0 at a rising clk edge resets the block.
REQ-006 SHALL have ports req0_i/req1_i  input  1  transfer request from requester 0/1; held until its done pulse.
REQ-007 SHALL have ports write0_i/write1_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports addr0_i/addr1_i  input  ADDR_W  transfer address.
REQ-009 SHALL have ports wdata0_i/wdata1_i  input  DATA_W  write data.
REQ-010 SHALL have ports done0_o/done1_o  output  1  one-cycle completion pulse to requester.
REQ-011 SHALL have ports err0_o/err1_o  output  1  timeout flag, valid with done pulse.
REQ-012 SHALL have ports rdata0_o/rdata1_o  output  DATA_W  read data, valid with done pulse.
REQ-013 SHALL have APB ports psel_o, penable_o, pwrite_o (output 1), paddr_o (output ADDR_W), pwdata_o (output DATA_W), pready_i (input 1), prdata_i (input DATA_W).

Function
REQ-014 SHALL register all outputs; no combinational path from any input to any output.
REQ-015 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-016 IDLE: at an edge with any req high, SHALL grant one requester, latch its write/addr/wdata onto pwrite_o/paddr_o/pwdata_o, set psel_o=1, penable_o=0, go SETUP.
REQ-017 Grant SHALL be round-robin: single request wins; both high -> requester not granted last; last-grant pointer resets to 1 so requester 0 wins the first tie.
REQ-018 SETUP: next edge SHALL go ACCESS unconditionally with penable_o=1 and clear wait counter.
REQ-019 ACCESS with pready_i=1 at an edge: psel_o=0, penable_o=0, granted done=1, err=0, rdata=prdata_i if read (unchanged if write), update last-grant pointer, go IDLE.
REQ-020 ACCESS with pready_i=0: wait counter (8 bits) SHALL increment; if counter equals TIMEOUT-1, abort as REQ-019 but with err=1 and rdata unchanged.
REQ-021 paddr_o/pwrite_o/pwdata_o SHALL hold constant from SETUP through end of ACCESS; requester input changes mid-transfer SHALL be ignored.
REQ-022 Latency: request sampled at edge N -> psel_o high after N, penable_o high after N+1, done earliest after N+2 (zero-wait slave).
REQ-023 done/err SHALL be single-cycle pulses; the done cycle is an IDLE cycle, so back-to-back transfers have one idle cycle minimum between psel_o deassert and reassert.
REQ-024 A requester whose req drops mid-transfer SHALL still get its transfer completed and its done pulse.
REQ-025 Only the granted requester's done/err/rdata SHALL change; the other's rdata holds.
REQ-026 Requesters SHALL drop req in the done cycle; a req still high at the edge after done is a new request.

Reset
REQ-027 On reset=0 at an edge: state IDLE, psel_o/penable_o/pwrite_o=0, paddr_o/pwdata_o=0, done*/err*=0, rdata*=0, wait counter=0, last-grant=1.
REQ-028 Reset mid-transfer SHALL abort immediately with no done pulse; reset has priority over all inputs.

Verification
REQ-029 Single read: req0, addr0=0xDEADCAFE, pready=1 in first ACCESS, prdata=0x12345678 -> psel 1 cycle then psel+penable 1 cycle, paddr=0xDEADCAFE, pwrite=0, done0 one cycle, rdata0=0x12345678.
REQ-030 Single write with 3 wait states: req1, write1=1, addr1=0x10, wdata1=0xA5A5A5A5 -> pwdata stable 0xA5A5A5A5 for SETUP + 4 ACCESS cycles, done1 pulse, err1=0.
REQ-031 Contention: req0 and req1 high together, both held -> grant order 0,1,0,1 with one idle cycle between transfers.
REQ-032 Timeout: TIMEOUT=4, pready held 0 -> abort at 4th ACCESS edge, done0=1, err0=1, psel/penable return to 0.
REQ-033 Reset mid-ACCESS: reset=0 for one edge -> all outputs at reset values next cycle, no done pulse, next req0 granted normally.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// APB master-side bus bundle for the two-requester arbiter.
// Signal names carry the arbiter-relative direction so they line up with the block's port list.
interface apb_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pready_i;
  logic [DATA_W-1:0] prdata_i;

  // Arbiter side: drives the request phase, samples the slave response.
  modport master (
    output psel_o,
    output penable_o,
    output pwrite_o,
    output paddr_o,
    output pwdata_o,
    input  pready_i,
    input  prdata_i
  );

  // Slave side: the mirror image.
  modport slave (
    input  psel_o,
    input  penable_o,
    input  pwrite_o,
    input  paddr_o,
    input  pwdata_o,
    output pready_i,
    output prdata_i
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// All outputs are registered; transfers that see no pready for TIMEOUT ACCESS edges are
// aborted and flagged with err alongside the done pulse.
module apb_req_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              write0_i,
  input  logic              write1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              done0_o,
  output logic              done1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  apb_req_arbiter_if.master apb
);

  // Counter value at which the current ACCESS edge becomes the final (aborting) one.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e     state_q;
  logic       gnt_q;   // requester owning the current transfer
  logic       last_q;  // requester granted by the most recently completed transfer
  logic [7:0] wait_q;

  logic pick1;
  logic xfer_end;
  logic xfer_err;

  // Round-robin pick: a lone request wins, a tie goes to the requester not served last.
  always_comb begin
    pick1 = req1_i;
    if (req0_i && req1_i) begin
      pick1 = ~last_q;
    end
  end

  // ACCESS ends on pready, or on the timeout edge; pready takes priority over the abort.
  always_comb begin
    xfer_end = apb.pready_i || (wait_q == WaitLast);
    xfer_err = !apb.pready_i;
  end

  // Transfer FSM with every output registered; done/err default low so they pulse once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      gnt_q         <= 1'b0;
      last_q        <= 1'b1;
      wait_q        <= 8'd0;
      apb.psel_o    <= 1'b0;
      apb.penable_o <= 1'b0;
      apb.pwrite_o  <= 1'b0;
      apb.paddr_o   <= '0;
      apb.pwdata_o  <= '0;
      done0_o       <= 1'b0;
      done1_o       <= 1'b0;
      err0_o        <= 1'b0;
      err1_o        <= 1'b0;
      rdata0_o      <= '0;
      rdata1_o      <= '0;
    end else begin
      done0_o <= 1'b0;
      done1_o <= 1'b0;
      err0_o  <= 1'b0;
      err1_o  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req0_i || req1_i) begin
            gnt_q         <= pick1;
            apb.pwrite_o  <= pick1 ? write1_i : write0_i;
            apb.paddr_o   <= pick1 ? addr1_i : addr0_i;
            apb.pwdata_o  <= pick1 ? wdata1_i : wdata0_i;
            apb.psel_o    <= 1'b1;
            apb.penable_o <= 1'b0;
            state_q       <= StSetup;
          end
        end
        StSetup: begin
          apb.penable_o <= 1'b1;
          wait_q        <= 8'd0;
          state_q       <= StAccess;
        end
        StAccess: begin
          if (xfer_end) begin
            apb.psel_o    <= 1'b0;
            apb.penable_o <= 1'b0;
            last_q        <= gnt_q;
            state_q       <= StIdle;
            if (gnt_q) begin
              done1_o <= 1'b1;
              err1_o  <= xfer_err;
              if (!xfer_err && !apb.pwrite_o) begin
                rdata1_o <= apb.prdata_i;
              end
            end else begin
              done0_o <= 1'b1;
              err0_o  <= xfer_err;
              if (!xfer_err && !apb.pwrite_o) begin
                rdata0_o <= apb.prdata_i;
              end
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (TIMEOUT=4): read, waited write, contention,
// timeout abort and reset mid-transfer. Outputs are sampled 1 time unit after each rising edge.
module tb_apb_req_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, write0, write1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rd0, exp_rd1;
  logic        exp1;

  apb_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) apb_bus ();

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0_i   (req0),
    .req1_i   (req1),
    .write0_i (write0),
    .write1_i (write1),
    .addr0_i  (addr0),
    .addr1_i  (addr1),
    .wdata0_i (wdata0),
    .wdata1_i (wdata1),
    .done0_o  (done0),
    .done1_o  (done1),
    .err0_o   (err0),
    .err1_o   (err1),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1),
    .apb      (apb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_psel"}, 32'(apb_bus.psel_o), 32'd0);
    check({tag, "_penable"}, 32'(apb_bus.penable_o), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    {req0, req1, write0, write1} = 4'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    apb_bus.pready_i = 1'b0;
    apb_bus.prdata_i = '0;
    step();
    step();
    reset = 1'b1;

    // Reset values
    check_idle_bus("rst");
    check("rst_pwrite", 32'(apb_bus.pwrite_o), 32'd0);
    check("rst_paddr", apb_bus.paddr_o, 32'd0);
    check("rst_pwdata", apb_bus.pwdata_o, 32'd0);
    check("rst_done", {28'd0, done0, done1, err0, err1}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);

    // Single zero-wait read from requester 0
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'hDEADCAFE;
    step();
    check("rd_setup_psel", 32'(apb_bus.psel_o), 32'd1);
    check("rd_setup_penable", 32'(apb_bus.penable_o), 32'd0);
    check("rd_paddr", apb_bus.paddr_o, 32'hDEADCAFE);
    check("rd_pwrite", 32'(apb_bus.pwrite_o), 32'd0);
    apb_bus.pready_i = 1'b1; apb_bus.prdata_i = 32'h12345678;
    step();
    check("rd_access_psel", 32'(apb_bus.psel_o), 32'd1);
    check("rd_access_penable", 32'(apb_bus.penable_o), 32'd1);
    check("rd_access_done0", 32'(done0), 32'd0);
    step();
    check_idle_bus("rd_end");
    check("rd_done0", 32'(done0), 32'd1);
    check("rd_err0", 32'(err0), 32'd0);
    check("rd_done1", 32'(done1), 32'd0);
    check("rd_rdata0", rdata0, 32'h12345678);
    exp_rd0 = 32'h12345678;
    exp_rd1 = 32'd0;
    req0 = 1'b0; apb_bus.pready_i = 1'b0; apb_bus.prdata_i = 32'hFFFF0000;
    step();
    check("rd_done0_pulse", 32'(done0), 32'd0);
    check_idle_bus("rd_after");

    // Write from requester 1 with 3 wait states; inputs changed mid-transfer are ignored
    req1 = 1'b1; write1 = 1'b1; addr1 = 32'h10; wdata1 = 32'hA5A5A5A5;
    step();
    check("wr_setup_psel", 32'(apb_bus.psel_o), 32'd1);
    check("wr_pwrite", 32'(apb_bus.pwrite_o), 32'd1);
    check("wr_paddr", apb_bus.paddr_o, 32'h10);
    check("wr_setup_pwdata", apb_bus.pwdata_o, 32'hA5A5A5A5);
    addr1 = 32'hFF; wdata1 = 32'h0; write1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wr_acc_penable", 32'(apb_bus.penable_o), 32'd1);
      check("wr_acc_pwdata", apb_bus.pwdata_o, 32'hA5A5A5A5);
      check("wr_acc_paddr", apb_bus.paddr_o, 32'h10);
      check("wr_acc_done1", 32'(done1), 32'd0);
    end
    // Fourth ACCESS edge coincides with the timeout count; pready wins
    apb_bus.pready_i = 1'b1;
    step();
    check_idle_bus("wr_end");
    check("wr_done1", 32'(done1), 32'd1);
    check("wr_err1", 32'(err1), 32'd0);
    check("wr_rdata1_hold", rdata1, exp_rd1);
    check("wr_rdata0_hold", rdata0, exp_rd0);
    req1 = 1'b0; apb_bus.pready_i = 1'b0;
    step();
    check("wr_done1_pulse", 32'(done1), 32'd0);

    // Contention: both held, expect grants 0,1,0,1 with an idle cycle between
    req0 = 1'b1; req1 = 1'b1; write0 = 1'b0; write1 = 1'b0;
    addr0 = 32'h100; addr1 = 32'h200;
    apb_bus.pready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp1 = 1'(i % 2);
      apb_bus.prdata_i = 32'h1000 + 32'(i);
      step();
      check("cont_setup_psel", 32'(apb_bus.psel_o), 32'd1);
      check("cont_grant_paddr", apb_bus.paddr_o, exp1 ? 32'h200 : 32'h100);
      step();
      check("cont_access_penable", 32'(apb_bus.penable_o), 32'd1);
      step();
      if (exp1) exp_rd1 = 32'h1000 + 32'(i);
      else exp_rd0 = 32'h1000 + 32'(i);
      check_idle_bus("cont_gap");
      check("cont_done0", 32'(done0), 32'(!exp1));
      check("cont_done1", 32'(done1), 32'(exp1));
      check("cont_rdata0", rdata0, exp_rd0);
      check("cont_rdata1", rdata1, exp_rd1);
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    step();
    check_idle_bus("cont_after");

    // Timeout: pready held low, abort on the 4th ACCESS edge
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h44;
    apb_bus.pready_i = 1'b0; apb_bus.prdata_i = 32'hBAD0BAD0;
    step();
    check("to_setup_psel", 32'(apb_bus.psel_o), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_wait_psel", 32'(apb_bus.psel_o), 32'd1);
      check("to_wait_penable", 32'(apb_bus.penable_o), 32'd1);
      check("to_wait_done0", 32'(done0), 32'd0);
    end
    step();
    check_idle_bus("to_end");
    check("to_done0", 32'(done0), 32'd1);
    check("to_err0", 32'(err0), 32'd1);
    check("to_rdata0_hold", rdata0, exp_rd0);
    req0 = 1'b0;
    step();
    check("to_err0_pulse", 32'(err0), 32'd0);

    // Reset mid-ACCESS, then a tie must go to requester 0 again
    req1 = 1'b1; write1 = 1'b1; addr1 = 32'h55; wdata1 = 32'h99;
    step();
    check("rm_setup_psel", 32'(apb_bus.psel_o), 32'd1);
    step();
    check("rm_access_penable", 32'(apb_bus.penable_o), 32'd1);
    reset = 1'b0;
    step();
    check_idle_bus("rm_rst");
    check("rm_paddr", apb_bus.paddr_o, 32'd0);
    check("rm_pwdata", apb_bus.pwdata_o, 32'd0);
    check("rm_pwrite", 32'(apb_bus.pwrite_o), 32'd0);
    check("rm_done", {28'd0, done0, done1, err0, err1}, 32'd0);
    check("rm_rdata0", rdata0, 32'd0);
    check("rm_rdata1", rdata1, 32'd0);
    reset = 1'b1;
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h66;
    apb_bus.pready_i = 1'b1; apb_bus.prdata_i = 32'h77;
    step();
    check("rm_no_done1", 32'(done1), 32'd0);
    check("rm_tie_paddr", apb_bus.paddr_o, 32'h66);
    step();
    check("rm_penable", 32'(apb_bus.penable_o), 32'd1);
    step();
    check("rm_done0", 32'(done0), 32'd1);
    check("rm_done1_low", 32'(done1), 32'd0);
    check("rm_rdata0_new", rdata0, 32'h77);
    check("rm_rdata1_hold", rdata1, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
